rf_writeback: RTL and testbench

- Write-side master of the 8-bit register file: owns the `we`/`ptr_w`/`di` write port and the `r_overflow` flag.
- Merges two result streams, ALU results (single cycle) and data-memory load returns (variable latency, in order), into a single registered write stream.
- Tracks outstanding loads and produces the decode-stage `stall` for read-after-load and write-after-load hazards.
- Sits between execute/memory and the register file; decode consumes `stall`.

---
 rtl/rf_wb_pkg.sv | 14 +
 rtl/rf_writeback_if.sv | 48 ++++
 rtl/rf_wb_fifo.sv | 70 +++++++
 rtl/rf_writeback.sv | 148 ++++++++++++++
 tb/tb_rf_writeback.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback block: write-source select and ALU FIFO entry.
package rf_wb_pkg;
   localparam int DW_DEF = 8;
   localparam int AW_DEF = 5;

   typedef enum logic [1:0] {WB_NONE, WB_MEM, WB_ALUQ, WB_ALU} wb_src_e;

   // Entry widths follow the package defaults; the top's DW/AW default to the same values.
   typedef struct packed {
      logic [AW_DEF-1:0] ptr;
      logic [DW_DEF-1:0] data;
      logic              ovf;
   } alu_entry_t;
endpackage

// File: rtl/rf_writeback_if.sv
// Bundle of result streams, decode hazard inputs and register-file write port.
// RF_WB_BYPASS_EN adds the combinational forwarding outputs fwd_valid/fwd_ptr/fwd_data.
interface rf_writeback_if #(
   parameter int DW = rf_wb_pkg::DW_DEF,
   parameter int AW = rf_wb_pkg::AW_DEF
);
   logic          alu_valid;
   logic [AW-1:0] alu_ptr;
   logic [DW-1:0] alu_data;
   logic          alu_ovf;
   logic          ld_issue;
   logic [AW-1:0] ld_ptr;
   logic          mem_valid;
   logic [DW-1:0] mem_data;
   logic [AW-1:0] src_a;
   logic [AW-1:0] src_b;
   logic          src_b_const;
   logic [AW-1:0] dst_chk;
   logic          we;
   logic [AW-1:0] ptr_w;
   logic [DW-1:0] di;
   logic          r_overflow;
   logic          stall;
   logic          ld_err;
`ifdef RF_WB_BYPASS_EN
   logic          fwd_valid;
   logic [AW-1:0] fwd_ptr;
   logic [DW-1:0] fwd_data;
`endif

   modport master (
      output alu_valid, alu_ptr, alu_data, alu_ovf, ld_issue, ld_ptr, mem_valid, mem_data,
             src_a, src_b, src_b_const, dst_chk,
      input  we, ptr_w, di, r_overflow, stall, ld_err
`ifdef RF_WB_BYPASS_EN
      , fwd_valid, fwd_ptr, fwd_data
`endif
   );

   modport slave (
      input  alu_valid, alu_ptr, alu_data, alu_ovf, ld_issue, ld_ptr, mem_valid, mem_data,
             src_a, src_b, src_b_const, dst_chk,
      output we, ptr_w, di, r_overflow, stall, ld_err
`ifdef RF_WB_BYPASS_EN
      , fwd_valid, fwd_ptr, fwd_data
`endif
   );
endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO exposing every slot plus a per-slot valid mask for hazard compares.
// Pop is applied before push, so a full FIFO accepts a push in a popping cycle.
module rf_wb_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  T                         din_i,
   input  logic                     pop_i,
   output T                         head_o,
   output T     [DEPTH-1:0]         ent_o,
   output logic [DEPTH-1:0]         vld_o,
   output logic [$clog2(DEPTH)-1:0] rd_idx_o,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic                     full_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   T     [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d, off;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_pop, do_push;

   always_comb begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q != CNT_FULL) || do_pop);
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      if (do_pop) rd_d = rd_q + 1'b1;
      if (do_push) begin
         mem_d[wr_q] = din_i;
         wr_d        = wr_q + 1'b1;
      end
      cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
   end

   // Slot i is live when its distance from the read pointer is below the count.
   always_comb begin
      off   = '0;
      vld_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = PW'(i) - rd_q;
         vld_o[i] = {1'b0, off} < cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o   = mem_q[rd_q];
   assign ent_o    = mem_q;
   assign rd_idx_o = rd_q;
   assign cnt_o    = cnt_q;
   assign full_o   = (cnt_q == CNT_FULL);
endmodule

// File: rtl/rf_writeback.sv
// Register-file write master: merges load returns and ALU results into one registered write
// stream and raises decode stall on load/ALU hazards. RF_WB_BYPASS_EN enables forwarding outputs.
module rf_writeback
   import rf_wb_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF,
   parameter int ALUQ_DEPTH = 2,
   parameter int LDQ_DEPTH  = 2
) (
   input logic           clk,
   input logic           reset,
   rf_writeback_if.slave bus
);
   localparam int AQ_PW = $clog2(ALUQ_DEPTH);
   localparam int LQ_PW = $clog2(LDQ_DEPTH);
   localparam logic [AQ_PW:0] AQ_STALL_CNT = (AQ_PW+1)'(ALUQ_DEPTH-1);
`ifdef RF_WB_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   alu_entry_t                       alu_in, aluq_head;
   alu_entry_t [ALUQ_DEPTH-1:0]      aluq_ent;
   logic       [ALUQ_DEPTH-1:0]      aluq_vld, aq_msk;
   logic       [AQ_PW-1:0]           aluq_rd;
   logic       [AQ_PW:0]             aluq_cnt;
   logic                             aluq_full, aluq_push, aluq_pop;
   logic       [AW-1:0]              ldq_head;
   logic       [LDQ_DEPTH-1:0][AW-1:0] ldq_ent;
   logic       [LDQ_DEPTH-1:0]       ldq_vld, ld_msk;
   logic       [LQ_PW-1:0]           ldq_rd;
   logic       [LQ_PW:0]             ldq_cnt;
   logic                             ldq_full, ldq_empty, ldq_pop;

   wb_src_e       sel;
   logic [AW-1:0] sel_ptr, ptr_w_q, ptr_w_d;
   logic [DW-1:0] sel_data, di_q, di_d;
   logic          sel_ovf, we_q, we_d, r_overflow_q, r_overflow_d, ld_err_q, ld_err_d;
   logic          hit, stall;

   assign alu_in    = '{ptr: bus.alu_ptr, data: bus.alu_data, ovf: bus.alu_ovf};
   assign ldq_empty = (ldq_cnt == '0);

   rf_wb_fifo #(.DEPTH(ALUQ_DEPTH), .T(alu_entry_t)) u_aluq (
      .clk(clk), .reset(reset), .push_i(aluq_push), .din_i(alu_in), .pop_i(aluq_pop),
      .head_o(aluq_head), .ent_o(aluq_ent), .vld_o(aluq_vld), .rd_idx_o(aluq_rd),
      .cnt_o(aluq_cnt), .full_o(aluq_full)
   );

   rf_wb_fifo #(.DEPTH(LDQ_DEPTH), .T(logic [AW-1:0])) u_ldq (
      .clk(clk), .reset(reset), .push_i(bus.ld_issue), .din_i(bus.ld_ptr), .pop_i(ldq_pop),
      .head_o(ldq_head), .ent_o(ldq_ent), .vld_o(ldq_vld), .rd_idx_o(ldq_rd),
      .cnt_o(ldq_cnt), .full_o(ldq_full)
   );

   // Any mem_valid owns the write slot, even a spurious one, so the FIFO head waits.
   always_comb begin
      sel      = WB_NONE;
      sel_ptr  = '0;
      sel_data = '0;
      sel_ovf  = 1'b0;
      if (bus.mem_valid) begin
         if (!ldq_empty) begin
            sel      = WB_MEM;
            sel_ptr  = ldq_head;
            sel_data = bus.mem_data;
         end
      end else if (aluq_cnt != '0) begin
         sel      = WB_ALUQ;
         sel_ptr  = aluq_head.ptr;
         sel_data = aluq_head.data;
         sel_ovf  = aluq_head.ovf;
      end else if (bus.alu_valid) begin
         sel      = WB_ALU;
         sel_ptr  = bus.alu_ptr;
         sel_data = bus.alu_data;
         sel_ovf  = bus.alu_ovf;
      end
   end

   assign ldq_pop   = (sel == WB_MEM);
   assign aluq_pop  = (sel == WB_ALUQ);
   assign aluq_push = bus.alu_valid && (sel != WB_ALU);

   always_comb begin
      we_d         = (sel != WB_NONE) && (sel_ptr != '0);
      ptr_w_d      = (sel != WB_NONE) ? sel_ptr  : ptr_w_q;
      di_d         = (sel != WB_NONE) ? sel_data : di_q;
      r_overflow_d = (sel == WB_ALUQ || sel == WB_ALU) ? sel_ovf : r_overflow_q;
      ld_err_d     = ld_err_q | (bus.mem_valid & ldq_empty);
   end

   // With forwarding, the entry leaving this cycle is visible on fwd_* and need not stall.
   always_comb begin
      ld_msk = ldq_vld;
      aq_msk = aluq_vld;
      if (BYPASS_EN && sel == WB_MEM)  ld_msk[ldq_rd]  = 1'b0;
      if (BYPASS_EN && sel == WB_ALUQ) aq_msk[aluq_rd] = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < LDQ_DEPTH; i++) begin
         if (ld_msk[i] && ((bus.src_a != '0 && ldq_ent[i] == bus.src_a) ||
                           (!bus.src_b_const && bus.src_b != '0 && ldq_ent[i] == bus.src_b) ||
                           (ldq_ent[i] == bus.dst_chk)))
            hit = 1'b1;
      end
      for (int i = 0; i < ALUQ_DEPTH; i++) begin
         if (aq_msk[i] && (aluq_ent[i].ptr == bus.src_a || aluq_ent[i].ptr == bus.src_b))
            hit = 1'b1;
      end
      stall = hit | (aluq_cnt >= AQ_STALL_CNT) | (ldq_full & ~bus.mem_valid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q         <= 1'b0;
         ptr_w_q      <= '0;
         di_q         <= '0;
         r_overflow_q <= 1'b0;
         ld_err_q     <= 1'b0;
      end else begin
         we_q         <= we_d;
         ptr_w_q      <= ptr_w_d;
         di_q         <= di_d;
         r_overflow_q <= r_overflow_d;
         ld_err_q     <= ld_err_d;
      end
   end

   assign bus.we         = we_q;
   assign bus.ptr_w      = ptr_w_q;
   assign bus.di         = di_q;
   assign bus.r_overflow = r_overflow_q;
   assign bus.ld_err     = ld_err_q;
   assign bus.stall      = stall;
`ifdef RF_WB_BYPASS_EN
   assign bus.fwd_valid  = (sel != WB_NONE);
   assign bus.fwd_ptr    = sel_ptr;
   assign bus.fwd_data   = sel_data;
`endif

   // Upstream honours stall, so a push into a full queue without a pop is a protocol error.
   a_ldq_no_drop: assert property (@(posedge clk) disable iff (reset)
      !(bus.ld_issue && ldq_full && !ldq_pop));
   a_aluq_no_drop: assert property (@(posedge clk) disable iff (reset)
      !(aluq_push && aluq_full && !aluq_pop));
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_rf_writeback;
   import rf_wb_pkg::*;
   localparam int AW = 5;
   localparam int DW = 8;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rf_writeback_if #(.DW(DW), .AW(AW)) bus();
   rf_writeback #(.DW(DW), .AW(AW), .ALUQ_DEPTH(2), .LDQ_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [AW-1:0] ptr;
      logic [DW-1:0] data;
      logic          ovf;
      logic          we;
      logic          ro;
   } vec_t;
   vec_t tbl [6];

   typedef struct {
      logic [AW-1:0] ptr;
      logic [DW-1:0] data;
      logic          ovf;
   } ment_t;
   logic [AW-1:0] mq_ld[$];
   ment_t         mq_alu[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.alu_valid = 0; bus.alu_ptr = '0; bus.alu_data = '0; bus.alu_ovf = 0;
      bus.ld_issue = 0; bus.ld_ptr = '0; bus.mem_valid = 0; bus.mem_data = '0;
      bus.src_a = '0; bus.src_b = '0; bus.src_b_const = 0; bus.dst_chk = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string nm, input logic we, input logic [AW-1:0] p, input logic [DW-1:0] d);
      chk({nm, "_we"}, bus.we, we);
      chk({nm, "_ptr"}, bus.ptr_w, p);
      chk({nm, "_di"}, bus.di, d);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   function automatic logic model_stall(input logic mv, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                                        input logic sbc, input logic [AW-1:0] dc);
      logic s;
      s = 1'b0;
      for (int i = 0; i < mq_ld.size(); i++) begin
         if (!(BYP && i == 0 && mv))
            if ((sa != 0 && mq_ld[i] == sa) || (!sbc && sb != 0 && mq_ld[i] == sb) || mq_ld[i] == dc)
               s = 1'b1;
      end
      for (int i = 0; i < mq_alu.size(); i++) begin
         if (!(BYP && i == 0 && !mv))
            if (mq_alu[i].ptr == sa || mq_alu[i].ptr == sb) s = 1'b1;
      end
      if (mq_alu.size() >= 1) s = 1'b1;
      if (mq_ld.size() == 2 && !mv) s = 1'b1;
      return s;
   endfunction

   initial begin
      logic          mv, sbc, wr, e_we, e_ovf;
      logic [AW-1:0] sa, sb, dc, e_ptr;
      logic [DW-1:0] e_di;
      int            op;
      ment_t         me;

      tbl[0] = '{5'd3,  8'h5A, 1'b1, 1'b1, 1'b1};
      tbl[1] = '{5'd31, 8'hA5, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{5'd0,  8'hFF, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{5'd1,  8'h00, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{5'd0,  8'h3C, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{5'd17, 8'h81, 1'b1, 1'b1, 1'b1};

      idle();
      reset = 1'b1;
      #3;
      chk_wr("rst", 1'b0, '0, '0);
      chk("rst_ovf", bus.r_overflow, 0);
      chk("rst_err", bus.ld_err, 0);
      chk("rst_stall", bus.stall, 0);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Single ALU writes from idle: direct path, one-cycle pulse, pointer 0 suppresses we.
      for (int i = 0; i < 6; i++) begin
         bus.alu_valid = 1; bus.alu_ptr = tbl[i].ptr; bus.alu_data = tbl[i].data; bus.alu_ovf = tbl[i].ovf;
         step();
         idle();
         chk_wr("tbl", tbl[i].we, tbl[i].ptr, tbl[i].data);
         chk("tbl_ovf", bus.r_overflow, tbl[i].ro);
         step();
         chk("tbl_pulse", bus.we, 0);
         chk("tbl_hold", bus.ptr_w, tbl[i].ptr);
      end

      // Collision: load return wins, ALU result queued and written next cycle.
      bus.ld_issue = 1; bus.ld_ptr = 5'd4;
      step();
      idle();
      bus.mem_valid = 1; bus.mem_data = 8'h11;
      bus.alu_valid = 1; bus.alu_ptr = 5'd2; bus.alu_data = 8'h22; bus.alu_ovf = 0;
      step();
      idle();
      chk_wr("col_mem", 1'b1, 5'd4, 8'h11);
      chk("col_mem_ovf", bus.r_overflow, 1);
      #1 chk("col_fifo_stall", bus.stall, 1);
      step();
      chk_wr("col_alu", 1'b1, 5'd2, 8'h22);
      chk("col_alu_ovf", bus.r_overflow, 0);
      #1 chk("col_empty_stall", bus.stall, 0);

      // Load hazard on src_a / src_b, immediate src_b exempt.
      step();
      bus.ld_issue = 1; bus.ld_ptr = 5'd5;
      step();
      idle();
      bus.src_a = 5'd5;
      #1 chk("haz_a", bus.stall, 1);
      step();
      chk("haz_a_hold", bus.stall, 1);
      bus.src_a = '0; bus.src_b = 5'd5; bus.src_b_const = 1;
      #1 chk("haz_b_const", bus.stall, 0);
      bus.src_b_const = 0;
      #1 chk("haz_b", bus.stall, 1);
      bus.src_b = '0; bus.src_a = 5'd5; bus.mem_valid = 1; bus.mem_data = 8'h77;
      #1 chk("haz_pop", bus.stall, BYP ? 0 : 1);
      step();
      bus.mem_valid = 0;
      #1 chk("haz_clear", bus.stall, 0);
      chk_wr("haz_wr", 1'b1, 5'd5, 8'h77);

      // Pointer 0 on both sources.
      idle();
      bus.alu_valid = 1; bus.alu_ptr = '0; bus.alu_data = 8'hFF; bus.alu_ovf = 1;
      step();
      idle();
      chk_wr("p0_alu", 1'b0, 5'd0, 8'hFF);
      chk("p0_alu_ovf", bus.r_overflow, 1);
      bus.ld_issue = 1; bus.ld_ptr = '0;
      step();
      idle();
      #1 chk("p0_waw", bus.stall, 1);
      bus.mem_valid = 1; bus.mem_data = 8'h99;
      step();
      idle();
      chk_wr("p0_mem", 1'b0, 5'd0, 8'h99);
      chk("p0_mem_ovf", bus.r_overflow, 1);
      #1 chk("p0_ldq_empty", bus.stall, 0);

      // LDQ full, simultaneous pop+push, order, spurious return.
      step();
      bus.ld_issue = 1; bus.ld_ptr = 5'd6;
      step();
      bus.ld_ptr = 5'd7;
      step();
      idle();
      #1 chk("full_stall", bus.stall, 1);
      bus.mem_valid = 1; bus.mem_data = 8'hA1; bus.ld_issue = 1; bus.ld_ptr = 5'd8;
      #1 chk("full_popush", bus.stall, 0);
      step();
      idle();
      chk_wr("full_w6", 1'b1, 5'd6, 8'hA1);
      #1 chk("full_still", bus.stall, 1);
      bus.mem_valid = 1; bus.mem_data = 8'hB2;
      step();
      chk_wr("full_w7", 1'b1, 5'd7, 8'hB2);
      bus.mem_data = 8'hC3;
      step();
      idle();
      chk_wr("full_w8", 1'b1, 5'd8, 8'hC3);
      #1 chk("full_drain", bus.stall, 0);
      chk("err_before", bus.ld_err, 0);
      bus.mem_valid = 1; bus.mem_data = 8'hDD;
      step();
      idle();
      chk_wr("spur", 1'b0, 5'd8, 8'hC3);
      chk("spur_err", bus.ld_err, 1);
      step();
      step();
      chk("spur_err_held", bus.ld_err, 1);

      // Asynchronous reset with two loads and one ALU entry pending.
      bus.ld_issue = 1; bus.ld_ptr = 5'd9;
      step();
      bus.ld_ptr = 5'd10;
      step();
      idle();
      bus.mem_valid = 1; bus.mem_data = 8'h44; bus.ld_issue = 1; bus.ld_ptr = 5'd11;
      bus.alu_valid = 1; bus.alu_ptr = 5'd12; bus.alu_data = 8'h5C; bus.alu_ovf = 1;
      step();
      idle();
      chk_wr("pre_rst", 1'b1, 5'd9, 8'h44);
      #2 reset = 1'b1;
      #1;
      chk_wr("arst", 1'b0, '0, '0);
      chk("arst_ovf", bus.r_overflow, 0);
      chk("arst_err", bus.ld_err, 0);
      chk("arst_stall", bus.stall, 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      step();
      chk("arst_no_alu", bus.we, 0);
      bus.mem_valid = 1;
      step();
      idle();
      chk("arst_spur_err", bus.ld_err, 1);
      chk("arst_spur_we", bus.we, 0);

      // Random traffic that honours stall, checked against the queue model.
      do_reset();
      e_we = 0; e_ptr = '0; e_di = '0; e_ovf = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         mv  = (mq_ld.size() != 0) && ($urandom_range(0, 2) != 0);
         sa  = AW'($urandom_range(0, 7));
         sb  = AW'($urandom_range(0, 7));
         dc  = AW'($urandom_range(0, 7));
         sbc = 1'($urandom_range(0, 1));
         op  = model_stall(mv, sa, sb, sbc, dc) ? 0 : $urandom_range(0, 2);
         bus.mem_valid = mv; bus.mem_data = DW'($urandom);
         bus.src_a = sa; bus.src_b = sb; bus.src_b_const = sbc; bus.dst_chk = dc;
         bus.alu_valid = (op == 1); bus.alu_ptr = dc; bus.alu_data = DW'($urandom);
         bus.alu_ovf = 1'($urandom_range(0, 1));
         bus.ld_issue = (op == 2); bus.ld_ptr = dc;
         #1 chk("rnd_stall", bus.stall, model_stall(mv, sa, sb, sbc, dc));
         wr = 0;
         if (mv) begin
            wr = 1; e_ptr = mq_ld.pop_front(); e_di = bus.mem_data;
         end else if (mq_alu.size() != 0) begin
            me = mq_alu.pop_front();
            wr = 1; e_ptr = me.ptr; e_di = me.data; e_ovf = me.ovf;
         end else if (op == 1) begin
            wr = 1; e_ptr = dc; e_di = bus.alu_data; e_ovf = bus.alu_ovf;
            op = 0;
         end
         if (op == 1) mq_alu.push_back('{dc, bus.alu_data, bus.alu_ovf});
         if (op == 2) mq_ld.push_back(dc);
         e_we = wr && (e_ptr != '0);
         step();
         chk_wr("rnd", e_we, e_ptr, e_di);
         chk("rnd_ovf", bus.r_overflow, e_ovf);
      end
      idle();
      chk("rnd_err", bus.ld_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
